// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: iterative signed/unsigned MULT/DIV, MTHI/MTLO, MFHI/MFLO read port.
// Optional MD_FAST_MUL_EN: single-cycle combinational multiply; division stays iterative.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for an op; MTHI/MTLO complete here
// MUL   | shift-add multiply, one multiplier bit per edge
// DIV   | restoring divide, one quotient bit per edge
// FIX   | sign correction and HI/LO commit
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] read_data,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               is_div_q, is_div_d;
  logic               done_q, done_d;

  logic               op_mul, op_div, op_signed, neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_mul    = (op == 3'b000) || (op == 3'b001);
  assign op_div    = (op == 3'b010) || (op == 3'b011);
  assign op_signed = ~op[0];
  assign neg_a     = op_signed & src_a[WIDTH-1];
  assign neg_b     = op_signed & src_b[WIDTH-1];
  assign abs_a     = neg_a ? -src_a : src_a;
  assign abs_b     = neg_b ? -src_b : src_b;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

  assign prod_fix  = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix   = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    count_d  = count_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (op_mul) begin
            opnd_d   = abs_a;
            count_d  = '0;
            neg_lo_d = neg_a ^ neg_b;
            neg_hi_d = neg_a ^ neg_b;
            is_div_d = 1'b0;
`ifdef MD_FAST_MUL_EN
            acc_d    = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
            state_d  = S_FIX;
`else
            acc_d    = {{WIDTH{1'b0}}, abs_b};
            state_d  = S_MUL;
`endif
          end else if (op_div) begin
            opnd_d   = abs_b;
            acc_d    = {{WIDTH{1'b0}}, abs_a};
            count_d  = '0;
            // Divide-by-zero leaves the all-ones quotient un-negated.
            neg_lo_d = (neg_a ^ neg_b) & (src_b != '0);
            neg_hi_d = neg_a;
            is_div_d = 1'b1;
            state_d  = S_DIV;
          end else if (op == 3'b100) begin
            hi_d = src_a;
          end else if (op == 3'b101) begin
            lo_d = src_a;
          end
        end
      end
      S_MUL: begin
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                   acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A squash abandons the op without touching HI/LO, including at commit.
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      count_q  <= count_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign read_data = mf_sel ? hi_q : lo_q;
  assign stall     = busy & (start | mf_req);

endmodule
